game_sequencer: RTL and testbench

Top-level game-flow controller for the raccoon crossing game. It sequences the title, play, hit, level-up, game-over and win phases, and owns the lives and level counters. It produces the one-cycle movement enable and the respawn strobe that drive the raccoon position controller. It sits between the debounced buttons and collision logic on one side, and the raccoon controller and display logic on the other.

---
 rtl/game_sequencer_pkg.sv | 29 ++
 rtl/game_sequencer_tick_gen.sv | 50 +++++
 rtl/game_sequencer.sv | 145 ++++++++++++++
 tb/tb_game_sequencer.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/game_sequencer_pkg.sv
// game_sequencer_pkg: constants shared by the game-flow controller and the display logic.
//   - state_e: state codes carried on o_State (IDLE=0 .. WIN=5) so the display can decode them.
//   - CNT_W: width of the shared tick/phase counter.
//   - MAX_LEVEL_DEFAULT, START_LIVES_DEFAULT: default game configuration.
//   - speedup_period(): per-level movement-tick period used when GAME_SPEEDUP_EN is defined.
package game_sequencer_pkg;

  localparam int unsigned CNT_W               = 25;
  localparam int unsigned MAX_LEVEL_DEFAULT   = 9;
  localparam int unsigned START_LIVES_DEFAULT = 3;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StPlay     = 3'd1,
    StHit      = 3'd2,
    StLevelUp  = 3'd3,
    StGameOver = 3'd4,
    StWin      = 3'd5
  } state_e;

  // period = base - (level-1) * (base >> 4); level is always >= 1.
  function automatic logic [CNT_W-1:0] speedup_period(input logic [CNT_W-1:0] i_base,
                                                      input logic [3:0]       i_level);
    logic [CNT_W-1:0] w_step;
    w_step = i_base >> 4;
    return i_base - CNT_W'(i_level - 4'd1) * w_step;
  endfunction

endpackage

// File: rtl/game_sequencer_tick_gen.sv
// game_sequencer_tick_gen: free-running 25-bit counter with a registered one-cycle tick.
// Ports:
//   i_Clk, i_Rst   - clock, asynchronous active-high reset
//   i_Clear        - forces the counter to 0 on the next edge (and suppresses the tick)
//   i_En           - allows the tick register to fire on the next edge
//   i_Period[24:0] - tick period in clocks; tick is high while the count equals period-1
//   o_Tick         - one-cycle tick, aligned with the cycle whose count reaches period-1
//   o_Count[24:0]  - current count, reused by the owner as a phase timer
module game_sequencer_tick_gen
  import game_sequencer_pkg::*;
(
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Clear,
  input  logic             i_En,
  input  logic [CNT_W-1:0] i_Period,
  output logic             o_Tick,
  output logic [CNT_W-1:0] o_Count
);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_d;
  logic [CNT_W-1:0] w_last;
  logic             r_tick;

  assign w_last = i_Period - CNT_W'(1);

  // >= rather than == so a period that shrinks mid-count still wraps within one new period.
  always_comb begin
    w_count_d = r_count + CNT_W'(1);
    if (i_Clear || (r_count >= w_last)) begin
      w_count_d = '0;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_count <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_count <= w_count_d;
      // Look ahead one count so the registered tick lines up with count == period-1.
      r_tick  <= i_En && !i_Clear && (w_count_d >= w_last);
    end
  end

  assign o_Tick  = r_tick;
  assign o_Count = r_count;

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: game-flow controller for the raccoon crossing game.
// Sequences IDLE, PLAY, HIT, LEVEL_UP, GAME_OVER and WIN; owns the lives and level counters.
// Ports:
//   i_Clk, i_Rst             - clock, asynchronous active-high reset
//   i_Start                  - debounced start button (rising edge starts/restarts)
//   i_Collision, i_Goal      - collision and top-row indications from the playfield
//   o_Move_Tick              - one-cycle movement enable, PLAY only
//   o_Respawn                - one-cycle strobe on the first cycle of every PLAY entry
//   o_Freeze                 - 1 in every state except PLAY
//   o_Level[3:0], o_Lives[1:0], o_State[2:0] - registered game status
// Configuration macro: GAME_SPEEDUP_EN - when defined the tick period shrinks with the level;
// otherwise the period is TICK_DIV at every level.
module game_sequencer
  import game_sequencer_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 2_000_000,
  parameter int unsigned HIT_CYCLES   = 12_500_000,
  parameter int unsigned LEVEL_CYCLES = 12_500_000,
  parameter int unsigned START_LIVES  = START_LIVES_DEFAULT,
  parameter int unsigned MAX_LEVEL    = MAX_LEVEL_DEFAULT
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Start,
  input  logic       i_Collision,
  input  logic       i_Goal,
  output logic       o_Move_Tick,
  output logic       o_Respawn,
  output logic       o_Freeze,
  output logic [3:0] o_Level,
  output logic [1:0] o_Lives,
  output logic [2:0] o_State
);

  localparam logic [1:0]       LIVES_INIT = 2'(START_LIVES);
  localparam logic [3:0]       LEVEL_LAST = 4'(MAX_LEVEL);
  localparam logic [CNT_W-1:0] HIT_LAST   = CNT_W'(HIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LVL_LAST   = CNT_W'(LEVEL_CYCLES - 1);

  state_e           r_state, w_state_d;
  logic [3:0]       r_level, w_level_d;
  logic [1:0]       r_lives, w_lives_d;
  logic             r_freeze;
  logic             r_respawn;
  logic             r_start_prev;
  logic             w_start_edge;
  logic             w_change;
  logic             w_tick_en;
  logic [CNT_W-1:0] w_play_period;
  logic [CNT_W-1:0] w_period;
  logic [CNT_W-1:0] w_count;

  assign w_start_edge = i_Start && !r_start_prev;

`ifdef GAME_SPEEDUP_EN
  assign w_play_period = speedup_period(CNT_W'(TICK_DIV), r_level);
`else
  assign w_play_period = CNT_W'(TICK_DIV);
`endif

  // Outside PLAY the counter is a phase timer; a full-range period keeps it from wrapping early.
  assign w_period  = (r_state == StPlay) ? w_play_period : '1;
  assign w_change  = (w_state_d != r_state);
  assign w_tick_en = (r_state == StPlay) && (w_state_d == StPlay);

  always_comb begin
    w_state_d = r_state;
    w_level_d = r_level;
    w_lives_d = r_lives;
    case (r_state)
      StIdle: begin
        if (w_start_edge) begin
          w_level_d = 4'd1;
          w_lives_d = LIVES_INIT;
          w_state_d = StPlay;
        end
      end
      StPlay: begin
        // Collision takes priority over goal.
        if (i_Collision) begin
          w_lives_d = (r_lives == 2'd0) ? 2'd0 : r_lives - 2'd1;
          w_state_d = (r_lives <= 2'd1) ? StGameOver : StHit;
        end else if (i_Goal) begin
          w_state_d = StLevelUp;
        end
      end
      StHit: begin
        if (w_count >= HIT_LAST) begin
          w_state_d = StPlay;
        end
      end
      StLevelUp: begin
        if (w_count >= LVL_LAST) begin
          if (r_level >= LEVEL_LAST) begin
            w_state_d = StWin;
          end else begin
            w_level_d = r_level + 4'd1;
            w_state_d = StPlay;
          end
        end
      end
      StGameOver, StWin: begin
        if (w_start_edge) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_state      <= StIdle;
      r_level      <= 4'd1;
      r_lives      <= LIVES_INIT;
      r_freeze     <= 1'b1;
      r_respawn    <= 1'b0;
      r_start_prev <= 1'b1;  // a button held through reset is not a start edge
    end else begin
      r_state      <= w_state_d;
      r_level      <= w_level_d;
      r_lives      <= w_lives_d;
      r_freeze     <= (w_state_d != StPlay);
      r_respawn    <= (w_state_d == StPlay) && (r_state != StPlay);
      r_start_prev <= i_Start;
    end
  end

  game_sequencer_tick_gen u_tick_gen (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .i_Clear  (w_change),
    .i_En     (w_tick_en),
    .i_Period (w_period),
    .o_Tick   (o_Move_Tick),
    .o_Count  (w_count)
  );

  assign o_Respawn = r_respawn;
  assign o_Freeze  = r_freeze;
  assign o_Level   = r_level;
  assign o_Lives   = r_lives;
  assign o_State   = r_state;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: each driven cycle pushes the expected output snapshot
// {state, level, lives, freeze, tick, respawn}; it is popped and compared after the clock edge.
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       i_Rst = 1'b1;
  logic       i_Start = 1'b0;
  logic       i_Collision = 1'b0;
  logic       i_Goal = 1'b0;
  logic       o_Move_Tick, o_Respawn, o_Freeze;
  logic [3:0] o_Level;
  logic [1:0] o_Lives;
  logic [2:0] o_State;

  int n_checks = 0;
  int n_fails  = 0;
  int play_k   = 0;
  logic [11:0] sb_q[$];

`ifdef GAME_SPEEDUP_EN
  localparam int P2 = 15;  // 16 - (2-1)*(16>>4)
`else
  localparam int P2 = 16;
`endif

  game_sequencer #(
    .TICK_DIV     (16),
    .HIT_CYCLES   (3),
    .LEVEL_CYCLES (3),
    .START_LIVES  (2),
    .MAX_LEVEL    (2)
  ) dut (
    .i_Clk       (clk),
    .i_Rst       (i_Rst),
    .i_Start     (i_Start),
    .i_Collision (i_Collision),
    .i_Goal      (i_Goal),
    .o_Move_Tick (o_Move_Tick),
    .o_Respawn   (o_Respawn),
    .o_Freeze    (o_Freeze),
    .o_Level     (o_Level),
    .o_Lives     (o_Lives),
    .o_State     (o_State)
  );

  always #5 clk = ~clk;

  wire [11:0] dut_snap = {o_State, o_Level, o_Lives, o_Freeze, o_Move_Tick, o_Respawn};

  function automatic logic [11:0] snap(input logic [2:0] st, input logic [3:0] lv,
                                       input logic [1:0] li, input logic tk, input logic rs);
    return {st, lv, li, (st != 3'd1), tk, rs};
  endfunction

  task automatic check_eq(input string tag, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: actual st=%0d lv=%0d li=%0d frz=%0b tk=%0b rs=%0b required st=%0d lv=%0d li=%0d frz=%0b tk=%0b rs=%0b",
               tag, act[11:9], act[8:5], act[4:3], act[2], act[1], act[0],
               exp[11:9], exp[8:5], exp[4:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic step(input logic st, input logic co, input logic go,
                      input logic [11:0] exp, input string tag);
    logic [11:0] e;
    @(negedge clk);
    i_Start = st;
    i_Collision = co;
    i_Goal = go;
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_eq(tag, dut_snap, e);
  endtask

  // Continue a PLAY phase; entry cycle is play_k=0, ticks at play_k % period == period-1.
  task automatic play_run(input int n, input logic [3:0] lv, input logic [1:0] li,
                          input int period, input string tag);
    for (int k = 0; k < n; k++) begin
      play_k++;
      step(1'b0, 1'b0, 1'b0, snap(3'd1, lv, li, (play_k % period) == period - 1, 1'b0), tag);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_values", dut_snap, snap(3'd0, 4'd1, 2'd2, 1'b0, 1'b0));
    @(negedge clk);
    i_Rst = 1'b0;

    // 1. Start and tick cadence
    step(0, 0, 0, snap(3'd0, 4'd1, 2'd2, 0, 0), "idle");
    step(0, 0, 0, snap(3'd0, 4'd1, 2'd2, 0, 0), "idle");
    step(1, 0, 0, snap(3'd1, 4'd1, 2'd2, 0, 1), "start");
    play_k = 0;
    play_run(47, 4'd1, 2'd2, 16, "tick_l1");

    // 2. Collision, collision held through HIT, second collision to GAME_OVER
    step(0, 1, 0, snap(3'd2, 4'd1, 2'd1, 0, 0), "hit_entry");
    step(0, 1, 0, snap(3'd2, 4'd1, 2'd1, 0, 0), "hit_hold");
    step(0, 1, 0, snap(3'd2, 4'd1, 2'd1, 0, 0), "hit_hold");
    step(0, 1, 0, snap(3'd1, 4'd1, 2'd1, 0, 1), "hit_exit");
    play_k = 0;
    play_run(5, 4'd1, 2'd1, 16, "play_after_hit");
    step(0, 1, 0, snap(3'd4, 4'd1, 2'd0, 0, 0), "game_over");
    step(0, 0, 0, snap(3'd4, 4'd1, 2'd0, 0, 0), "go_hold");
    step(1, 0, 0, snap(3'd0, 4'd1, 2'd0, 0, 0), "go_to_idle");
    step(0, 0, 0, snap(3'd0, 4'd1, 2'd0, 0, 0), "idle_after_go");
    step(1, 0, 0, snap(3'd1, 4'd1, 2'd2, 0, 1), "restart");
    play_k = 0;

    // 3. Level progression to WIN
    play_run(3, 4'd1, 2'd2, 16, "pre_goal");
    step(0, 0, 1, snap(3'd3, 4'd1, 2'd2, 0, 0), "lvl_entry");
    step(0, 0, 1, snap(3'd3, 4'd1, 2'd2, 0, 0), "lvl_hold");
    step(0, 0, 1, snap(3'd3, 4'd1, 2'd2, 0, 0), "lvl_hold");
    step(0, 0, 0, snap(3'd1, 4'd2, 2'd2, 0, 1), "lvl_exit");
    play_k = 0;
    play_run(2 * P2, 4'd2, 2'd2, P2, "tick_l2");
    step(0, 0, 1, snap(3'd3, 4'd2, 2'd2, 0, 0), "lvl2_entry");
    step(0, 0, 0, snap(3'd3, 4'd2, 2'd2, 0, 0), "lvl2_hold");
    step(0, 0, 0, snap(3'd3, 4'd2, 2'd2, 0, 0), "lvl2_hold");
    step(0, 0, 0, snap(3'd5, 4'd2, 2'd2, 0, 0), "win");
    step(0, 0, 0, snap(3'd5, 4'd2, 2'd2, 0, 0), "win_hold");
    step(1, 0, 0, snap(3'd0, 4'd2, 2'd2, 0, 0), "win_to_idle");
    step(0, 0, 0, snap(3'd0, 4'd2, 2'd2, 0, 0), "idle_after_win");
    step(1, 0, 0, snap(3'd1, 4'd1, 2'd2, 0, 1), "start3");
    play_k = 0;

    // 4. Collision beats goal
    play_run(2, 4'd1, 2'd2, 16, "pre_prio");
    step(0, 1, 1, snap(3'd2, 4'd1, 2'd1, 0, 0), "coll_goal_prio");
    step(0, 0, 0, snap(3'd2, 4'd1, 2'd1, 0, 0), "hit_mid");

    // 5. Asynchronous reset mid-HIT with start held through release
    #2;
    i_Start = 1'b1;
    i_Rst = 1'b1;
    #1;
    check_eq("async_reset", dut_snap, snap(3'd0, 4'd1, 2'd2, 0, 0));
    @(negedge clk);
    i_Rst = 1'b0;
    step(1, 0, 0, snap(3'd0, 4'd1, 2'd2, 0, 0), "start_held_rst");
    step(1, 0, 0, snap(3'd0, 4'd1, 2'd2, 0, 0), "start_held_rst");
    step(0, 0, 0, snap(3'd0, 4'd1, 2'd2, 0, 0), "idle_release");
    step(1, 0, 0, snap(3'd1, 4'd1, 2'd2, 0, 1), "start_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
